rtc_bus_sequencer: RTL and testbench
====================================

RTC_BUS_SEQUENCER -- requirements
Module: rtc_bus_sequencer

Interface
REQ-001 SHALL have parameter T_SETUP, default 2, cycles of bus setup before each strobe (>=1).
REQ-002 SHALL have parameter T_STROBE, default 8, cycles of each active-low strobe pulse (>=1).
REQ-003 SHALL have parameter T_HOLD, default 2, cycles of hold after each strobe (>=1).
REQ-004 SHALL have parameter T_TURN, default 4, cycles of bus turnaround between phases (>=1).
REQ-005 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port start  input  1  request a transaction; sampled only in IDLE.
REQ-008 SHALL have port rw  input  1  1 = write, 0 = read; latched with start.
REQ-009 SHALL have port busy  output  1  high from the cycle after accepted start through DONE.
REQ-010 SHALL have port done  output  1  one-cycle pulse at transaction end.
REQ-011 SHALL have port cs_n  output  1  RTC chip select, low in all non-IDLE/non-DONE states.
REQ-012 SHALL have port as_n  output  1  RTC address strobe, low only in ADDR_STROBE.
REQ-013 SHALL have port wr_n  output  1  RTC write strobe, low in ADDR_STROBE and write DATA_STROBE.
REQ-014 SHALL have port rd_n  output  1  RTC read strobe, low only in read DATA_STROBE.
REQ-015 SHALL have port bus_oe  output  1  drive enable for the bidirectional AD bus in the downstream mux.
REQ-016 SHALL have port ctrl_escribe  output  1  mux control: 1 = bus driven by FPGA.
REQ-017 SHALL have port sel_dato  output  1  mux phase select: 0 = address, 1 = data.
REQ-018 SHALL have port capture  output  1  one-cycle strobe telling the register bank to latch read data.

Function
REQ-019 SHALL implement states IDLE, ADDR_SETUP, ADDR_STROBE, ADDR_HOLD, TURN, DATA_SETUP, DATA_STROBE, DATA_HOLD, DONE.
REQ-020 SHALL leave IDLE for ADDR_SETUP on the edge where start=1, latching rw; start in any other state SHALL be ignored.
REQ-021 SHALL hold each timed state exactly its parameter count of cycles using one down-counter reloaded on state entry.
REQ-022 SHALL sequence ADDR_SETUP->ADDR_STROBE->ADDR_HOLD->TURN->DATA_SETUP->DATA_STROBE->DATA_HOLD->DONE->IDLE; DONE lasts one cycle.
REQ-023 SHALL drive bus_oe=1, ctrl_escribe=1, sel_dato=0 throughout the three address states.
REQ-024 SHALL drive bus_oe=0, ctrl_escribe=0, sel_dato=0 in TURN, IDLE and DONE.
REQ-025 SHALL drive, in the three data states, sel_dato=1 and bus_oe=ctrl_escribe=latched rw.
REQ-026 SHALL pulse capture for one cycle on the last DATA_STROBE cycle of a read only; never on writes.
REQ-027 SHALL generate all outputs from registers (no combinational path from start or rw to any output).
REQ-028 SHALL accept a new start in the IDLE cycle directly following DONE (back-to-back transactions).

Reset
REQ-029 SHALL on reset force IDLE, counter 0, busy=0, done=0, capture=0, cs_n=as_n=wr_n=rd_n=1, bus_oe=ctrl_escribe=sel_dato=0.
REQ-030 SHALL, on reset asserted mid-transaction, release all strobes and bus_oe immediately (asynchronously) and produce no done.

Configuration
REQ-031 SHALL, with RTC_SEQ_TURNAROUND_EN defined, include the TURN state for T_TURN cycles.
REQ-032 SHALL, without RTC_SEQ_TURNAROUND_EN, omit TURN: ADDR_HOLD proceeds directly to DATA_SETUP and T_TURN is unused.

Structure
REQ-033 SHALL place the state encoding type and the default timing constants in shared package rtc_bus_pkg.
REQ-034 SHALL be a single module; the phase counter SHALL NOT be a separate sub-module.

Verification (defaults, start sampled at edge 0)
REQ-035 SHALL verify write with macro defined: as_n low cycles 3-10, wr_n low 3-10 and 19-26, bus_oe=0 cycles 13-16, done at cycle 29, capture never high.
REQ-036 SHALL verify read with macro defined: rd_n low cycles 19-26, bus_oe=0 cycles 13-28, capture high in cycle 26 only, done at cycle 29.
REQ-037 SHALL verify write without macro: no TURN cycles, wr_n low 15-22, done at cycle 25.
REQ-038 SHALL verify start pulsed at cycles 5 and 20 during a transaction is ignored: exactly one done.
REQ-039 SHALL verify reset asserted at cycle 20 of a read: rd_n, cs_n high and bus_oe low in the same cycle, busy=0, no done, no capture.
REQ-040 SHALL verify back-to-back: start held high continuously yields done pulses 30 cycles apart (macro defined).

Source files
------------

// File: rtl/rtc_bus_pkg.sv
// Shared state encoding, default bus timing and registered output bundle
// for the RTC bus sequencer.
package rtc_bus_pkg;

  localparam int DEF_T_SETUP  = 2;
  localparam int DEF_T_STROBE = 8;
  localparam int DEF_T_HOLD   = 2;
  localparam int DEF_T_TURN   = 4;

  typedef enum logic [3:0] {
    IDLE,
    ADDR_SETUP,
    ADDR_STROBE,
    ADDR_HOLD,
    TURN,
    DATA_SETUP,
    DATA_STROBE,
    DATA_HOLD,
    DONE
  } state_t;

  typedef struct packed {
    logic busy;
    logic done;
    logic cs_n;
    logic as_n;
    logic wr_n;
    logic rd_n;
    logic bus_oe;
    logic ctrl_escribe;
    logic sel_dato;
    logic capture;
  } pins_t;

  localparam pins_t PINS_IDLE = '{
    busy: 1'b0, done: 1'b0, cs_n: 1'b1, as_n: 1'b1, wr_n: 1'b1, rd_n: 1'b1,
    bus_oe: 1'b0, ctrl_escribe: 1'b0, sel_dato: 1'b0, capture: 1'b0
  };

  // Pin values for the state being entered; last_cycle marks the final cycle of a timed state.
  function automatic pins_t pins_for(input state_t s, input logic write, input logic last_cycle);
    pins_t p;
    logic  addr_phase;
    logic  data_phase;
    p          = PINS_IDLE;
    addr_phase = (s == ADDR_SETUP) || (s == ADDR_STROBE) || (s == ADDR_HOLD);
    data_phase = (s == DATA_SETUP) || (s == DATA_STROBE) || (s == DATA_HOLD);
    p.busy         = (s != IDLE);
    p.done         = (s == DONE);
    p.cs_n         = (s == IDLE) || (s == DONE);
    p.as_n         = (s != ADDR_STROBE);
    p.wr_n         = !((s == ADDR_STROBE) || ((s == DATA_STROBE) && write));
    p.rd_n         = !((s == DATA_STROBE) && !write);
    p.bus_oe       = addr_phase || (data_phase && write);
    p.ctrl_escribe = addr_phase || (data_phase && write);
    p.sel_dato     = data_phase;
    p.capture      = (s == DATA_STROBE) && !write && last_cycle;
    return p;
  endfunction

endpackage

// File: rtl/rtc_bus_sequencer.sv
// Multiplexed address/data RTC bus sequencer: address phase, optional bus
// turnaround (RTC_SEQ_TURNAROUND_EN), data phase, one-cycle DONE.
module rtc_bus_sequencer
  import rtc_bus_pkg::*;
#(
  parameter int T_SETUP  = DEF_T_SETUP,
  parameter int T_STROBE = DEF_T_STROBE,
  parameter int T_HOLD   = DEF_T_HOLD,
  parameter int T_TURN   = DEF_T_TURN
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic rw,
  output logic busy,
  output logic done,
  output logic cs_n,
  output logic as_n,
  output logic wr_n,
  output logic rd_n,
  output logic bus_oe,
  output logic ctrl_escribe,
  output logic sel_dato,
  output logic capture
);

  localparam int T_MAX_A = (T_SETUP > T_STROBE) ? T_SETUP : T_STROBE;
  localparam int T_MAX_B = (T_HOLD > T_TURN) ? T_HOLD : T_TURN;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int CW      = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          write, write_next;
  pins_t         pins;

  // Counter is loaded with count-1 on entry; the state is left when it reads zero.
  function automatic logic [CW-1:0] ld(input int t);
    return CW'(t - 1);
  endfunction

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    write_next = write;
    if (state == IDLE) begin
      if (start) begin
        state_next = ADDR_SETUP;
        cnt_next   = ld(T_SETUP);
        write_next = rw;
      end
    end else if (state == DONE) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else if (cnt != '0) begin
      cnt_next = cnt - 1'b1;
    end else begin
      case (state)
        ADDR_SETUP:  begin state_next = ADDR_STROBE; cnt_next = ld(T_STROBE); end
        ADDR_STROBE: begin state_next = ADDR_HOLD;   cnt_next = ld(T_HOLD);   end
`ifdef RTC_SEQ_TURNAROUND_EN
        ADDR_HOLD:   begin state_next = TURN;        cnt_next = ld(T_TURN);   end
`else
        ADDR_HOLD:   begin state_next = DATA_SETUP;  cnt_next = ld(T_SETUP);  end
`endif
        TURN:        begin state_next = DATA_SETUP;  cnt_next = ld(T_SETUP);  end
        DATA_SETUP:  begin state_next = DATA_STROBE; cnt_next = ld(T_STROBE); end
        DATA_STROBE: begin state_next = DATA_HOLD;   cnt_next = ld(T_HOLD);   end
        DATA_HOLD:   begin state_next = DONE;        cnt_next = '0;           end
        default:     begin state_next = IDLE;        cnt_next = '0;           end
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      write <= 1'b0;
      pins  <= PINS_IDLE;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      write <= write_next;
      pins  <= pins_for(state_next, write_next, cnt_next == '0);
    end
  end

  assign busy         = pins.busy;
  assign done         = pins.done;
  assign cs_n         = pins.cs_n;
  assign as_n         = pins.as_n;
  assign wr_n         = pins.wr_n;
  assign rd_n         = pins.rd_n;
  assign bus_oe       = pins.bus_oe;
  assign ctrl_escribe = pins.ctrl_escribe;
  assign sel_dato     = pins.sel_dato;
  assign capture      = pins.capture;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Self-checking bench for rtc_bus_sequencer: per-cycle scoreboard of all outputs,
// table of timing spot checks, plus ignore/back-to-back/async-reset sequences.
module tb_rtc_bus_sequencer;

  localparam int TS  = 2;
  localparam int TST = 8;
  localparam int TH  = 2;
  localparam int TT  = 4;
`ifdef RTC_SEQ_TURNAROUND_EN
  localparam int TURN_LEN = TT;
  localparam int B2B_GAP  = 30;
`else
  localparam int TURN_LEN = 0;
  localparam int B2B_GAP  = 26;
`endif
  // Cycle numbers (start sampled at edge 0, cycle k ends at edge k)
  localparam int AS_C   = 1 + TS;
  localparam int AH_C   = AS_C + TST;
  localparam int TN_C   = AH_C + TH;
  localparam int DS_C   = TN_C + TURN_LEN;
  localparam int DST_C  = DS_C + TS;
  localparam int DH_C   = DST_C + TST;
  localparam int DONE_C = DH_C + TH;

  localparam int B_BUSY = 9, B_DONE = 8, B_CSN = 7, B_ASN = 6, B_WRN = 5;
  localparam int B_RDN = 4, B_OE = 3, B_CE = 2, B_SD = 1, B_CAP = 0;
  localparam logic [9:0] IDLE_V = 10'b00_1111_0000;

  logic clk, reset, start, rw;
  logic busy, done, cs_n, as_n, wr_n, rd_n, bus_oe, ctrl_escribe, sel_dato, capture;
  logic [9:0] ov;
  assign ov = {busy, done, cs_n, as_n, wr_n, rd_n, bus_oe, ctrl_escribe, sel_dato, capture};

  rtc_bus_sequencer #(.T_SETUP(TS), .T_STROBE(TST), .T_HOLD(TH), .T_TURN(TT)) dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw),
    .busy(busy), .done(done), .cs_n(cs_n), .as_n(as_n), .wr_n(wr_n), .rd_n(rd_n),
    .bus_oe(bus_oe), .ctrl_escribe(ctrl_escribe), .sel_dato(sel_dato), .capture(capture)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int k; logic [9:0] v; } exp_t;
  typedef struct { logic w; int cyc; int sig; logic val; string name; } row_t;

  exp_t       exp_q[$];
  row_t       rows[$];
  logic [9:0] trace [0:63];
  int checks = 0, errors = 0;
  int cyc = 0, done_cnt = 0, cap_cnt = 0, done_prev = -1, done_last = -1;

  function automatic logic [9:0] model(input int k, input logic w);
    logic [9:0] v;
    logic addr, data, dstb;
    if (k < 1 || k > DONE_C) return IDLE_V;
    addr = (k < TN_C);
    data = (k >= DS_C) && (k < DONE_C);
    dstb = (k >= DST_C) && (k < DH_C);
    v[B_BUSY] = 1'b1;
    v[B_DONE] = (k == DONE_C);
    v[B_CSN]  = (k == DONE_C);
    v[B_ASN]  = !(k >= AS_C && k < AH_C);
    v[B_WRN]  = !((k >= AS_C && k < AH_C) || (dstb && w));
    v[B_RDN]  = !(dstb && !w);
    v[B_OE]   = addr || (data && w);
    v[B_CE]   = addr || (data && w);
    v[B_SD]   = data;
    v[B_CAP]  = !w && (k == DH_C - 1);
    return v;
  endfunction

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic push_range(input logic w, input int last);
    for (int k = 0; k <= last; k++) exp_q.push_back('{k, model(k, w)});
  endtask

  // Sample the current cycle at the falling edge, then move just past the next rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (done) begin done_cnt++; done_prev = done_last; done_last = cyc; end
    if (capture) cap_cnt++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      trace[e.k] = ov;
      checks++;
      if (ov !== e.v) begin
        errors++;
        $display("FAIL scoreboard k=%0d: got %b expected %b", e.k, ov, e.v);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_txn(input logic w);
    start = 1'b1; rw = w;
    push_range(w, DONE_C + 1);
    tick();
    start = 1'b0; rw = ~w;
    repeat (DONE_C + 1) tick();
    $display("txn rw=%0d complete, done at cycle %0d", w, DONE_C);
  endtask

  initial begin
    int d0, c0;
    reset = 1'b1; start = 1'b0; rw = 1'b0;
`ifdef RTC_SEQ_TURNAROUND_EN
    rows.push_back('{1'b1,  3, B_ASN,  1'b0, "w as_n@3"});
    rows.push_back('{1'b1, 10, B_ASN,  1'b0, "w as_n@10"});
    rows.push_back('{1'b1,  2, B_ASN,  1'b1, "w as_n@2"});
    rows.push_back('{1'b1, 11, B_ASN,  1'b1, "w as_n@11"});
    rows.push_back('{1'b1, 19, B_WRN,  1'b0, "w wr_n@19"});
    rows.push_back('{1'b1, 26, B_WRN,  1'b0, "w wr_n@26"});
    rows.push_back('{1'b1, 27, B_WRN,  1'b1, "w wr_n@27"});
    rows.push_back('{1'b1, 13, B_OE,   1'b0, "w oe@13"});
    rows.push_back('{1'b1, 16, B_OE,   1'b0, "w oe@16"});
    rows.push_back('{1'b1, 17, B_OE,   1'b1, "w oe@17"});
    rows.push_back('{1'b1, 29, B_DONE, 1'b1, "w done@29"});
    rows.push_back('{1'b1, 28, B_DONE, 1'b0, "w done@28"});
    rows.push_back('{1'b0, 19, B_RDN,  1'b0, "r rd_n@19"});
    rows.push_back('{1'b0, 26, B_RDN,  1'b0, "r rd_n@26"});
    rows.push_back('{1'b0, 18, B_RDN,  1'b1, "r rd_n@18"});
    rows.push_back('{1'b0, 13, B_OE,   1'b0, "r oe@13"});
    rows.push_back('{1'b0, 28, B_OE,   1'b0, "r oe@28"});
    rows.push_back('{1'b0, 26, B_CAP,  1'b1, "r cap@26"});
    rows.push_back('{1'b0, 25, B_CAP,  1'b0, "r cap@25"});
    rows.push_back('{1'b0, 27, B_CAP,  1'b0, "r cap@27"});
    rows.push_back('{1'b0, 29, B_DONE, 1'b1, "r done@29"});
`else
    rows.push_back('{1'b1,  3, B_ASN,  1'b0, "w as_n@3"});
    rows.push_back('{1'b1, 10, B_ASN,  1'b0, "w as_n@10"});
    rows.push_back('{1'b1, 13, B_OE,   1'b1, "w oe@13"});
    rows.push_back('{1'b1, 15, B_WRN,  1'b0, "w wr_n@15"});
    rows.push_back('{1'b1, 22, B_WRN,  1'b0, "w wr_n@22"});
    rows.push_back('{1'b1, 14, B_WRN,  1'b1, "w wr_n@14"});
    rows.push_back('{1'b1, 23, B_WRN,  1'b1, "w wr_n@23"});
    rows.push_back('{1'b1, 25, B_DONE, 1'b1, "w done@25"});
    rows.push_back('{1'b1, 24, B_DONE, 1'b0, "w done@24"});
    rows.push_back('{1'b0, 15, B_RDN,  1'b0, "r rd_n@15"});
    rows.push_back('{1'b0, 22, B_RDN,  1'b0, "r rd_n@22"});
    rows.push_back('{1'b0, 22, B_CAP,  1'b1, "r cap@22"});
    rows.push_back('{1'b0, 21, B_CAP,  1'b0, "r cap@21"});
    rows.push_back('{1'b0, 13, B_OE,   1'b0, "r oe@13"});
    rows.push_back('{1'b0, 25, B_DONE, 1'b1, "r done@25"});
`endif

    @(posedge clk);
    #1;
    check("reset outputs", int'(ov), int'(IDLE_V));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) tick();

    // Write then read, each followed by the timing spot-check table.
    for (int t = 0; t < 2; t++) begin
      logic w;
      w = (t == 0);
      c0 = cap_cnt;
      run_txn(w);
      for (int i = 0; i < rows.size(); i++)
        if (rows[i].w == w)
          check(rows[i].name, int'(trace[rows[i].cyc][rows[i].sig]), int'(rows[i].val));
      check(w ? "w capture count" : "r capture count", cap_cnt - c0, w ? 0 : 1);
    end

    // Start pulses mid-transaction are ignored; rw is latched only with the accepted start.
    d0 = done_cnt;
    start = 1'b1; rw = 1'b1;
    push_range(1'b1, DONE_C + 1);
    tick();
    for (int c = 1; c <= DONE_C + 1; c++) begin
      start = (c == 5) || (c == 20);
      rw = 1'b0;
      tick();
    end
    start = 1'b0;
    check("ignored start done count", done_cnt - d0, 1);
    $display("txn ignore-start complete");

    // Back-to-back reads with start held high.
    d0 = done_cnt;
    start = 1'b1; rw = 1'b0;
    push_range(1'b0, DONE_C);
    push_range(1'b0, DONE_C + 1);
    repeat (DONE_C + 1) tick();
    tick();
    start = 1'b0;
    repeat (DONE_C + 1) tick();
    check("b2b done count", done_cnt - d0, 2);
    check("b2b done spacing", done_last - done_prev, B2B_GAP);
    $display("txn back-to-back complete, spacing %0d", done_last - done_prev);

    // Asynchronous reset at cycle 20 of a read.
    start = 1'b1; rw = 1'b0;
    tick();
    start = 1'b0;
    repeat (19) tick();
    check("rd_n before reset", int'(rd_n), 0);
    d0 = done_cnt; c0 = cap_cnt;
    #2 reset = 1'b1;
    #1;
    check("reset rd_n", int'(rd_n), 1);
    check("reset cs_n", int'(cs_n), 1);
    check("reset bus_oe", int'(bus_oe), 0);
    check("reset busy", int'(busy), 0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (40) tick();
    check("reset no done", done_cnt - d0, 0);
    check("reset no capture", cap_cnt - c0, 0);
    check("post-reset idle", int'(ov), int'(IDLE_V));
    $display("txn reset-abort complete");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
